parity_frame_ctrl: RTL and testbench
====================================

# parity_frame_ctrl

Frame controller that sequences the serial parity datapath. It accepts parallel words over a valid/ready handshake and shifts each word out LSB-first as a serial bit stream. It accumulates running parity during the shift and appends the parity bit as the final bit of the frame. It sits between a parallel producer and the serial parity/link logic, and it reports the parity of each completed frame.

## Interface

Parameters:
- `WIDTH`, default 8: data bits per frame; legal range 2..32.
- `ODD`, default 0: 0 selects even parity (appended bit makes total ones even); 1 selects odd parity.

Ports:
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `in_valid`  input  1: producer has a word on `in_data`.
- `in_data`  input  WIDTH: parallel word to serialize.
- `in_ready`  output  1: controller accepts `in_data` this cycle.
- `flush`  input  1: synchronous abort of the current frame.
- `ser_x`  output  1: serial bit (data bits LSB first, then the parity bit).
- `ser_en`  output  1: `ser_x` carries a valid bit this cycle.
- `ser_last`  output  1: `ser_x` is the parity bit (last bit of the frame).
- `busy`  output  1: a frame is in progress (SHIFT or PARITY).
- `frame_done`  output  1: one-cycle pulse after a frame's parity bit.
- `par_out`  output  1: parity bit of the last completed frame; held until the next completion.

## Operation

State machine: IDLE, SHIFT, PARITY.
- **IDLE:** `in_ready`=1; `ser_en`=`ser_last`=`busy`=0; `ser_x`=0.
  - Accept when `in_valid`&`in_ready`: load shift register with `in_data`, clear bit counter and parity accumulator, go to SHIFT.
- **SHIFT:** `in_ready`=0; `ser_en`=1; `busy`=1; `ser_x`=shift register bit 0.
  - Each cycle: accumulator ^= `ser_x`, shift register shifts right by one, counter increments.
  - After the counter reaches WIDTH-1 (the WIDTH-th bit), go to PARITY.
- **PARITY:** `ser_en`=1; `ser_last`=1; `busy`=1; `ser_x`=accumulator ^ `ODD`; `in_ready`=1.
  - At the edge: `par_out` <= `ser_x`; `frame_done` <= 1 for one cycle.
  - If `in_valid`, load the next word and go to SHIFT (no gap); otherwise go to IDLE.
- `in_valid` in SHIFT is ignored; the producer holds the word until `in_ready`.
- `flush` has priority over all transitions.
  - Next state is IDLE; counter and accumulator are cleared; no `frame_done`; `par_out` is unchanged.
  - A word presented with `flush` high is not accepted (`in_ready` is forced to 0 while `flush`=1).
- Counter width is clog2(WIDTH); the counter never wraps past WIDTH-1.
- Accumulator is 1 bit (XOR of shifted bits).
- Reset (asynchronous, any state, including mid-frame):
  - State returns to IDLE; shift register, counter and accumulator clear.
  - Output reset values: `ser_x`=0, `ser_en`=0, `ser_last`=0, `busy`=0, `frame_done`=0, `par_out`=0, `in_ready`=1 (IDLE).
  - Handshakes while `rst_n`=0 are ignored.
  - A partially sent frame is discarded; no `frame_done`.

## Timing

- Word accepted at rising edge k.
  - Data bit i is driven on `ser_x` during cycle k+i (i=0..WIDTH-1).
  - The parity bit is driven during cycle k+WIDTH.
  - `frame_done` is high and `par_out` is updated during cycle k+WIDTH+1.
- Frame length is WIDTH+1 cycles. Sustained throughput is one word per WIDTH+1 cycles with `in_valid` held high, with `ser_en` continuously 1.
- Back-to-back frames: the `frame_done` pulse of frame n coincides with bit 0 of frame n+1.
- `in_ready`, `ser_x`, `ser_en`, `ser_last` and `busy` are decoded from registered state only, except `in_ready` gating by `flush`.
- `frame_done` and `par_out` are registered.

## Test plan

- **Even parity, single word.** Reset, WIDTH=8, ODD=0, `in_data`=8'hA5 for one handshake.
  - `ser_x` = 1,0,1,0,0,1,0,1 with `ser_en`=1, then parity bit 0 with `ser_last`=1.
  - `frame_done` pulses 9 cycles after acceptance; `par_out`=0.
- **Odd ones count.** `in_data`=8'h07 with ODD=0 → parity bit 1, `par_out`=1. Separate instance with ODD=1 and `in_data`=8'h00 → parity bit 1.
- **Back-to-back.** `in_valid` held high with 8'hFF then 8'h01.
  - 18 consecutive `ser_en` cycles; parity bits 0 then 1.
  - Two `frame_done` pulses 9 cycles apart; `in_ready` high only in IDLE/PARITY cycles.
- **Handshake hold.** Toggle `in_data` with `in_valid` high during SHIFT → ignored; serialized bits match the word sampled at acceptance; `in_ready`=0 throughout SHIFT.
- **Flush.** Assert `flush` during data bit 3 of 8'hA5 → next cycle IDLE, `ser_en`=0, no `frame_done`, `par_out` retains prior value. A new word then serializes correctly from bit 0.
- **Reset mid-frame.** Drop `rst_n` asynchronously during bit 5 → outputs immediately at reset values (`busy`=0, `par_out`=0, `in_ready`=1). After release, 8'h07 produces a correct frame with parity 1.

Source files
------------

// File: rtl/parity_frame_ctrl.sv
// Frame controller: serializes parallel words LSB-first and appends a parity bit.
module parity_frame_ctrl #(
   parameter int unsigned WIDTH = 8,
   parameter bit          ODD   = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   input  logic             flush,
   output logic             ser_x,
   output logic             ser_en,
   output logic             ser_last,
   output logic             busy,
   output logic             frame_done,
   output logic             par_out
);

   localparam int unsigned     CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             acc_q, acc_d;
   logic             par_q, par_d;
   logic             done_q, done_d;

   assign frame_done = done_q;
   assign par_out    = par_q;

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         acc_q   <= 1'b0;
         par_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         par_q   <= par_d;
         done_q  <= done_d;
      end
   end

   // Next-state and output decode; flush overrides every transition.
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      par_d    = par_q;
      done_d   = 1'b0;
      in_ready = 1'b0;
      ser_x    = 1'b0;
      ser_en   = 1'b0;
      ser_last = 1'b0;
      busy     = 1'b0;

      case (state_q)
         IDLE: begin
            in_ready = !flush;
            if (in_valid && !flush) begin
               shift_d = in_data;
               cnt_d   = '0;
               acc_d   = 1'b0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            ser_en  = 1'b1;
            busy    = 1'b1;
            ser_x   = shift_q[0];
            acc_d   = acc_q ^ shift_q[0];
            shift_d = shift_q >> 1;
            if (cnt_q == LAST_BIT) begin
               state_d = PARITY;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         PARITY: begin
            ser_en   = 1'b1;
            ser_last = 1'b1;
            busy     = 1'b1;
            ser_x    = acc_q ^ ODD;
            in_ready = !flush;
            par_d    = acc_q ^ ODD;
            done_d   = 1'b1;
            cnt_d    = '0;
            acc_d    = 1'b0;
            if (in_valid && !flush) begin
               shift_d = in_data;
               state_d = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (flush) begin
         state_d = IDLE;
         shift_d = '0;
         cnt_d   = '0;
         acc_d   = 1'b0;
         par_d   = par_q;
         done_d  = 1'b0;
      end
   end

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Bench for parity_frame_ctrl: even and odd instances driven in lockstep.
module tb_parity_frame_ctrl;

   localparam int unsigned W = 8;

   logic         clk      = 1'b0;
   logic         rst_n    = 1'b1;
   logic         in_valid = 1'b0;
   logic         flush    = 1'b0;
   logic [W-1:0] in_data  = '0;

   logic a_in_ready, a_ser_x, a_ser_en, a_ser_last, a_busy, a_frame_done, a_par_out;
   logic b_in_ready, b_ser_x, b_ser_en, b_ser_last, b_busy, b_frame_done, b_par_out;

   int vectors     = 0;
   int miscompares = 0;

   // Reference: parity of the last completed frame for each instance.
   logic par_a = 1'b0;
   logic par_b = 1'b0;
   logic [W-1:0] q[$];

   // Observation order: {ser_en, ser_last, busy, in_ready, ser_x, frame_done, par_out}
   wire [6:0] obs_a = {a_ser_en, a_ser_last, a_busy, a_in_ready, a_ser_x, a_frame_done, a_par_out};
   wire [6:0] obs_b = {b_ser_en, b_ser_last, b_busy, b_in_ready, b_ser_x, b_frame_done, b_par_out};

   parity_frame_ctrl #(.WIDTH(W), .ODD(1'b0)) dut_even (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(a_in_ready), .flush(flush), .ser_x(a_ser_x), .ser_en(a_ser_en),
      .ser_last(a_ser_last), .busy(a_busy), .frame_done(a_frame_done), .par_out(a_par_out)
   );

   parity_frame_ctrl #(.WIDTH(W), .ODD(1'b1)) dut_odd (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(b_in_ready), .flush(flush), .ser_x(b_ser_x), .ser_en(b_ser_en),
      .ser_last(b_ser_last), .busy(b_busy), .frame_done(b_frame_done), .par_out(b_par_out)
   );

   always #5 clk = ~clk;

   // Sends every word in q with in_valid held across frame boundaries, checking each cycle.
   task automatic stream(input string name, input bit toggle);
      logic [6:0] ea, eb;
      logic       pa;
      ea = {4'b0001, 1'b0, 1'b0, par_a};
      eb = {4'b0001, 1'b0, 1'b0, par_b};
      vectors++;
      if (obs_a !== ea) begin miscompares++; $display("FAIL %s idle even: got %b expected %b", name, obs_a, ea); end
      vectors++;
      if (obs_b !== eb) begin miscompares++; $display("FAIL %s idle odd: got %b expected %b", name, obs_b, eb); end
      in_valid = 1'b1;
      in_data  = q[0];
      for (int n = 0; n < q.size(); n++) begin
         for (int i = 0; i < W; i++) begin
            @(negedge clk);
            ea = {3'b101, 1'b0, q[n][i], (n > 0 && i == 0), par_a};
            eb = {3'b101, 1'b0, q[n][i], (n > 0 && i == 0), par_b};
            vectors++;
            if (obs_a !== ea) begin miscompares++; $display("FAIL %s even frame=%0d bit=%0d: got %b expected %b", name, n, i, obs_a, ea); end
            vectors++;
            if (obs_b !== eb) begin miscompares++; $display("FAIL %s odd frame=%0d bit=%0d: got %b expected %b", name, n, i, obs_b, eb); end
            in_valid = toggle;
            if (toggle) in_data = W'($urandom);
         end
         @(negedge clk);
         pa = ^q[n];
         ea = {3'b111, 1'b1, pa, 1'b0, par_a};
         eb = {3'b111, 1'b1, ~pa, 1'b0, par_b};
         vectors++;
         if (obs_a !== ea) begin miscompares++; $display("FAIL %s even parity frame=%0d: got %b expected %b", name, n, obs_a, ea); end
         vectors++;
         if (obs_b !== eb) begin miscompares++; $display("FAIL %s odd parity frame=%0d: got %b expected %b", name, n, obs_b, eb); end
         par_a = pa;
         par_b = ~pa;
         if (n + 1 < q.size()) begin
            in_valid = 1'b1;
            in_data  = q[n+1];
         end else begin
            in_valid = 1'b0;
         end
      end
      @(negedge clk);
      ea = {4'b0001, 1'b0, 1'b1, par_a};
      eb = {4'b0001, 1'b0, 1'b1, par_b};
      vectors++;
      if (obs_a !== ea) begin miscompares++; $display("FAIL %s done even: got %b expected %b", name, obs_a, ea); end
      vectors++;
      if (obs_b !== eb) begin miscompares++; $display("FAIL %s done odd: got %b expected %b", name, obs_b, eb); end
      @(negedge clk);
      ea = {4'b0001, 1'b0, 1'b0, par_a};
      eb = {4'b0001, 1'b0, 1'b0, par_b};
      vectors++;
      if (obs_a !== ea) begin miscompares++; $display("FAIL %s post even: got %b expected %b", name, obs_a, ea); end
      vectors++;
      if (obs_b !== eb) begin miscompares++; $display("FAIL %s post odd: got %b expected %b", name, obs_b, eb); end
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'hA5;
      repeat (2) @(negedge clk);
      vectors++;
      if (obs_a !== 7'b0001000) begin miscompares++; $display("FAIL reset even: got %b expected %b", obs_a, 7'b0001000); end
      vectors++;
      if (obs_b !== 7'b0001000) begin miscompares++; $display("FAIL reset odd: got %b expected %b", obs_b, 7'b0001000); end
      rst_n    = 1'b1;
      in_valid = 1'b0;
      par_a    = 1'b0;
      par_b    = 1'b0;
      @(negedge clk);
      vectors++;
      if (obs_a !== 7'b0001000) begin miscompares++; $display("FAIL reset_release even: got %b expected %b", obs_a, 7'b0001000); end
      vectors++;
      if (obs_b !== 7'b0001000) begin miscompares++; $display("FAIL reset_release odd: got %b expected %b", obs_b, 7'b0001000); end
   endtask

   task automatic test_single();
      q.delete(); q.push_back(8'hA5);
      stream("even_a5", 1'b0);
      q.delete(); q.push_back(8'h07);
      stream("ones_07", 1'b0);
      q.delete(); q.push_back(8'h00);
      stream("zero_00", 1'b0);
   endtask

   task automatic test_back_to_back();
      q.delete(); q.push_back(8'hFF); q.push_back(8'h01);
      stream("b2b_ff_01", 1'b0);
      q.delete();
      for (int k = 0; k < 4; k++) q.push_back(W'($urandom));
      stream("b2b_random", 1'b0);
   endtask

   task automatic test_hold();
      q.delete(); q.push_back(W'($urandom));
      stream("hold", 1'b1);
      q.delete(); q.push_back(W'($urandom)); q.push_back(W'($urandom));
      stream("hold_b2b", 1'b1);
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++) begin
         q.delete();
         for (int k = 0; k < int'($urandom_range(1, 3)); k++) q.push_back(W'($urandom));
         stream("random", 1'($urandom_range(0, 1)));
      end
   endtask

   task automatic test_flush();
      logic [6:0] ea, eb;
      logic [W-1:0] d;
      d = 8'hA5;
      flush    = 1'b1;
      in_valid = 1'b1;
      in_data  = d;
      #1;
      vectors++;
      if ({a_in_ready, b_in_ready} !== 2'b00) begin miscompares++; $display("FAIL flush_gates_ready: got %b expected %b", {a_in_ready, b_in_ready}, 2'b00); end
      @(negedge clk);
      ea = {7'b0000000} | {6'b0, par_a};
      eb = {7'b0000000} | {6'b0, par_b};
      vectors++;
      if (obs_a !== ea) begin miscompares++; $display("FAIL flush_no_accept even: got %b expected %b", obs_a, ea); end
      vectors++;
      if (obs_b !== eb) begin miscompares++; $display("FAIL flush_no_accept odd: got %b expected %b", obs_b, eb); end
      flush = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         ea = {3'b101, 1'b0, d[i], 1'b0, par_a};
         eb = {3'b101, 1'b0, d[i], 1'b0, par_b};
         vectors++;
         if (obs_a !== ea) begin miscompares++; $display("FAIL flush_bits even bit=%0d: got %b expected %b", i, obs_a, ea); end
         vectors++;
         if (obs_b !== eb) begin miscompares++; $display("FAIL flush_bits odd bit=%0d: got %b expected %b", i, obs_b, eb); end
      end
      flush = 1'b1;
      @(negedge clk);
      ea = {6'b000000, par_a};
      eb = {6'b000000, par_b};
      vectors++;
      if (obs_a !== ea) begin miscompares++; $display("FAIL flush_abort even: got %b expected %b", obs_a, ea); end
      vectors++;
      if (obs_b !== eb) begin miscompares++; $display("FAIL flush_abort odd: got %b expected %b", obs_b, eb); end
      flush = 1'b0;
      @(negedge clk);
      ea = {4'b0001, 1'b0, 1'b0, par_a};
      eb = {4'b0001, 1'b0, 1'b0, par_b};
      vectors++;
      if (obs_a !== ea) begin miscompares++; $display("FAIL flush_idle even: got %b expected %b", obs_a, ea); end
      vectors++;
      if (obs_b !== eb) begin miscompares++; $display("FAIL flush_idle odd: got %b expected %b", obs_b, eb); end
      q.delete(); q.push_back(8'hA5);
      stream("after_flush", 1'b0);
   endtask

   task automatic test_reset_mid();
      in_valid = 1'b1;
      in_data  = W'($urandom);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
      vectors++;
      if ({a_busy, b_busy} !== 2'b11) begin miscompares++; $display("FAIL reset_mid_busy: got %b expected %b", {a_busy, b_busy}, 2'b11); end
      #2 rst_n = 1'b0;
      #1;
      par_a = 1'b0;
      par_b = 1'b0;
      vectors++;
      if (obs_a !== 7'b0001000) begin miscompares++; $display("FAIL reset_mid even: got %b expected %b", obs_a, 7'b0001000); end
      vectors++;
      if (obs_b !== 7'b0001000) begin miscompares++; $display("FAIL reset_mid odd: got %b expected %b", obs_b, 7'b0001000); end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'h3C;
      @(negedge clk);
      vectors++;
      if (obs_a !== 7'b0001000) begin miscompares++; $display("FAIL reset_ignore even: got %b expected %b", obs_a, 7'b0001000); end
      vectors++;
      if (obs_b !== 7'b0001000) begin miscompares++; $display("FAIL reset_ignore odd: got %b expected %b", obs_b, 7'b0001000); end
      in_valid = 1'b0;
      rst_n    = 1'b1;
      @(negedge clk);
      q.delete(); q.push_back(8'h07);
      stream("after_reset", 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_hold();
      test_random();
      test_flush();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
